// File: rtl/chunk_addsub.sv
// chunk_addsub: multi-cycle two's-complement adder/subtractor.
//   Works through the operands CHUNK bits per clock and keeps the carry/borrow
//   in a register between chunks. Operands are accepted with valid/ready and
//   the result is offered with valid/ready. Input and output never overlap.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands/mode valid
//   in_ready   block can accept operands (registered)
//   a, b       operands (WIDTH bits)
//   mode       0 = a+b, 1 = a-b
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts result
//   result     sum or difference mod 2^WIDTH
//   cb         add: carry-out, sub: borrow-out (a < b unsigned)
//   overflow   signed two's-complement overflow
//
// Configuration macro
//   ADDSUB_SAT_EN  when defined, an overflowing result clamps to the signed
//                  limit on the side of a's sign; overflow still reads 1.
//
// States
//   S_IDLE | waiting for operands, in_ready=1
//   S_RUN  | one chunk added per cycle
//   S_DONE | result offered, out_valid=1
module chunk_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cb,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_params
      $error("chunk_addsub: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // b already inverted for subtraction
  logic             mode_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  int               base;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK:0]   ch_sum;
  logic             ovf_next;

  assign base   = int'(cnt) * CHUNK;
  assign a_ch   = a_q[base +: CHUNK];
  assign b_ch   = b_q[base +: CHUNK];
  assign ch_sum = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};

  // Only meaningful on the last chunk, where ch_sum holds the result MSB.
  assign ovf_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (ch_sum[CHUNK-1] != a_q[WIDTH-1]);

`ifdef ADDSUB_SAT_EN
  logic [WIDTH-1:0] sat_val;
  assign sat_val = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      cb        <= 1'b0;
      overflow  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= mode ? ~b : b;
            carry    <= mode;      // +1 completes the two's-complement negate
            mode_q   <= mode;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_RUN: begin
          result[base +: CHUNK] <= ch_sum[CHUNK-1:0];
          carry <= ch_sum[CHUNK];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Subtraction carry-out of 1 means no borrow, hence the inversion.
            cb        <= mode_q ^ ch_sum[CHUNK];
            overflow  <= ovf_next;
            out_valid <= 1'b1;
            state     <= S_DONE;
`ifdef ADDSUB_SAT_EN
            if (ovf_next) begin
              result <= sat_val;
            end
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
